// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state and operation-class types for the ALU control-step sequencer.
package alu_seq_pkg;

    localparam logic [4:0] OP_NOT = 5'b10010;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6
    } state_e;

    typedef enum logic [1:0] {
        CLS_UNARY,
        CLS_BINARY,
        CLS_WIDE
    } op_class_e;

endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot decode with enable; an index at or beyond N yields all zeros.
module onehot_decoder #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (en_i && (idx_i == IDX_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Clocked T3..T6 control-step sequencer for one ALU command on the shared bus datapath.
// state | meaning: IDLE wait/accept | T3 ra->Y | T4 operand B, ALU->Z | T5 Z.lo out, write | T6 Z.hi out (wide)
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OPC_W    = 5
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [IDX_W-1:0]    rd,
    input  logic [IDX_W-1:0]    ra,
    input  logic [IDX_W-1:0]    rb,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                lo_in,
    output logic                hi_in,
    output logic [OPC_W-1:0]    alu_opcode
);

    localparam logic [IDX_W:0] NR = (IDX_W + 1)'(NUM_REGS);

    function automatic op_class_e classify(input logic [OPC_W-1:0] opc);
        if (opc == OPC_W'(OP_NOT) || opc == OPC_W'(OP_NEG)) return CLS_UNARY;
        if (opc == OPC_W'(OP_MUL) || opc == OPC_W'(OP_DIV)) return CLS_WIDE;
        return CLS_BINARY;
    endfunction

    state_e           state_q;
    op_class_e        cls_q;
    logic [OPC_W-1:0] opc_q;
    logic [IDX_W-1:0] rb_q;
    logic [IDX_W-1:0] rd_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [IDX_W-1:0] in_idx_q;
    logic             out_en_q;
    logic             in_en_q;
    logic             busy_q, done_q, err_q;
    logic             y_in_q, z_in_q, zlo_out_q, zhi_out_q, lo_in_q, hi_in_q;
    logic [OPC_W-1:0] alu_opc_q;

    op_class_e in_cls;
    logic      cmd_bad;

    // Operand indices that the decoded class never reads are not range-checked.
    assign in_cls  = classify(opcode);
    assign cmd_bad = ({1'b0, ra} >= NR)
                   | (({1'b0, rb} >= NR) && (in_cls != CLS_UNARY))
                   | (({1'b0, rd} >= NR) && (in_cls != CLS_WIDE));

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_BINARY;
            opc_q     <= '0;
            rb_q      <= '0;
            rd_q      <= '0;
            out_idx_q <= '0;
            in_idx_q  <= '0;
            out_en_q  <= 1'b0;
            in_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            y_in_q    <= 1'b0;
            z_in_q    <= 1'b0;
            zlo_out_q <= 1'b0;
            zhi_out_q <= 1'b0;
            lo_in_q   <= 1'b0;
            hi_in_q   <= 1'b0;
            alu_opc_q <= '0;
        end else begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            y_in_q    <= 1'b0;
            z_in_q    <= 1'b0;
            zlo_out_q <= 1'b0;
            zhi_out_q <= 1'b0;
            lo_in_q   <= 1'b0;
            hi_in_q   <= 1'b0;
            out_en_q  <= 1'b0;
            in_en_q   <= 1'b0;
            alu_opc_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            cls_q     <= in_cls;
                            opc_q     <= opcode;
                            rb_q      <= rb;
                            rd_q      <= rd;
                            state_q   <= ST_T3;
                            busy_q    <= 1'b1;
                            out_idx_q <= ra;
                            out_en_q  <= 1'b1;
                            y_in_q    <= 1'b1;
                        end
                    end
                end
                ST_T3: begin
                    state_q   <= ST_T4;
                    busy_q    <= 1'b1;
                    out_idx_q <= rb_q;
                    out_en_q  <= (cls_q != CLS_UNARY);
                    z_in_q    <= 1'b1;
                    alu_opc_q <= opc_q;
                end
                ST_T4: begin
                    state_q   <= ST_T5;
                    busy_q    <= 1'b1;
                    zlo_out_q <= 1'b1;
                    alu_opc_q <= opc_q;
                    if (cls_q == CLS_WIDE) begin
                        lo_in_q <= 1'b1;
                    end else begin
                        in_idx_q <= rd_q;
                        in_en_q  <= 1'b1;
                        done_q   <= 1'b1;
                    end
                end
                ST_T5: begin
                    if (cls_q == CLS_WIDE) begin
                        state_q   <= ST_T6;
                        busy_q    <= 1'b1;
                        zhi_out_q <= 1'b1;
                        hi_in_q   <= 1'b1;
                        done_q    <= 1'b1;
                        alu_opc_q <= opc_q;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_T6: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    onehot_decoder #(
        .N     (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_out_dec (
        .idx_i    (out_idx_q),
        .en_i     (out_en_q),
        .onehot_o (reg_out)
    );

    onehot_decoder #(
        .N     (NUM_REGS),
        .IDX_W (IDX_W)
    ) u_in_dec (
        .idx_i    (in_idx_q),
        .en_i     (in_en_q),
        .onehot_o (reg_in)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign y_in       = y_in_q;
    assign z_in       = z_in_q;
    assign zlo_out    = zlo_out_q;
    assign zhi_out    = zhi_out_q;
    assign lo_in      = lo_in_q;
    assign hi_in      = hi_in_q;
    assign alu_opcode = alu_opc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an 8-register file: a command-level model
// expands each accepted command into its expected per-cycle outputs, checked every cycle.
module tb_alu_op_sequencer;

    localparam int NR = 8;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] reg_out;
        logic [7:0] reg_in;
        logic       y_in;
        logic       z_in;
        logic       zlo;
        logic       zhi;
        logic       lo;
        logic       hi;
        logic [4:0] alu;
    } obs_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [4:0] opcode;
    logic [3:0] rd, ra, rb;
    logic       busy, done, err;
    logic [7:0] reg_out, reg_in;
    logic       y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;
    logic [4:0] alu_opcode;

    int total = 0;
    int bad   = 0;

    alu_op_sequencer #(
        .NUM_REGS (NR),
        .IDX_W    (4),
        .OPC_W    (5)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .opcode     (opcode),
        .rd         (rd),
        .ra         (ra),
        .rb         (rb),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .reg_out    (reg_out),
        .reg_in     (reg_in),
        .y_in       (y_in),
        .z_in       (z_in),
        .zlo_out    (zlo_out),
        .zhi_out    (zhi_out),
        .lo_in      (lo_in),
        .hi_in      (hi_in),
        .alu_opcode (alu_opcode)
    );

    always #5 clk = ~clk;

    obs_t act;
    assign act = {busy, done, err, reg_out, reg_in, y_in, z_in, zlo_out, zhi_out,
                  lo_in, hi_in, alu_opcode};

    obs_t exp_cur = '0;
    obs_t q[$];
    bit   armed = 1'b0;

    // Command-level model: each accepted command becomes a list of output frames.
    function automatic void model_cmd(input logic [4:0] opc, input int a, input int b, input int d);
        obs_t f;
        bit   un;
        bit   wide;
        un   = (opc == 5'b10010) || (opc == 5'b10001);
        wide = (opc == 5'b01111) || (opc == 5'b10000);
        if (a >= NR || (!un && b >= NR) || (!wide && d >= NR)) begin
            f = '0;
            f.err = 1'b1;
            q.push_back(f);
            return;
        end
        f = '0; f.busy = 1'b1; f.reg_out = 8'(1 << a); f.y_in = 1'b1;
        q.push_back(f);
        f = '0; f.busy = 1'b1; f.reg_out = un ? 8'h00 : 8'(1 << b); f.z_in = 1'b1; f.alu = opc;
        q.push_back(f);
        f = '0; f.busy = 1'b1; f.zlo = 1'b1; f.alu = opc;
        if (wide) f.lo = 1'b1;
        else begin
            f.reg_in = 8'(1 << d);
            f.done   = 1'b1;
        end
        q.push_back(f);
        if (wide) begin
            f = '0; f.busy = 1'b1; f.zhi = 1'b1; f.hi = 1'b1; f.done = 1'b1; f.alu = opc;
            q.push_back(f);
        end
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            q.delete();
            exp_cur = '0;
            armed   = 1'b1;
        end else begin
            if (!exp_cur.busy && start) model_cmd(opcode, int'(ra), int'(rb), int'(rd));
            exp_cur = (q.size() > 0) ? q.pop_front() : '0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            total++;
            if (act !== exp_cur) begin
                bad++;
                $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act, exp_cur);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] opc, input logic [3:0] d, input logic [3:0] a,
                         input logic [3:0] b);
        opcode = opc; rd = d; ra = a; rb = b; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        clr = 1'b1; start = 1'b0; opcode = '0; rd = '0; ra = '0; rb = '0;
        cyc(); cyc();
        chk("rst_busy", busy, 0);
        chk("rst_reg_out", reg_out, 0);
        chk("rst_alu", alu_opcode, 0);
        clr = 1'b0;
        cyc();

        // NOT ra=1 rd=0
        issue(5'b10010, 4'd0, 4'd1, 4'd0);
        chk("not_t3_reg_out", reg_out, 8'h02);
        chk("not_t3_y_in", y_in, 1);
        chk("not_t3_busy", busy, 1);
        cyc();
        chk("not_t4_reg_out", reg_out, 8'h00);
        chk("not_t4_z_in", z_in, 1);
        chk("not_t4_alu", alu_opcode, 5'b10010);
        cyc();
        chk("not_t5_reg_in", reg_in, 8'h01);
        chk("not_t5_zlo", zlo_out, 1);
        chk("not_t5_done", done, 1);
        cyc();
        chk("not_after_busy", busy, 0);

        // ADD ra=2 rb=3 rd=4
        issue(5'b00011, 4'd4, 4'd2, 4'd3);
        chk("add_t3_reg_out", reg_out, 8'h04);
        cyc();
        chk("add_t4_reg_out", reg_out, 8'h08);
        chk("add_t4_alu", alu_opcode, 5'b00011);
        cyc();
        chk("add_t5_reg_in", reg_in, 8'h10);
        chk("add_t5_done", done, 1);
        cyc();

        // MUL ra=5 rb=6, rd out of range but unused
        issue(5'b01111, 4'd9, 4'd5, 4'd6);
        chk("mul_t3_reg_out", reg_out, 8'h20);
        cyc();
        chk("mul_t4_reg_out", reg_out, 8'h40);
        cyc();
        chk("mul_t5_lo_in", lo_in, 1);
        chk("mul_t5_reg_in", reg_in, 8'h00);
        chk("mul_t5_done", done, 0);
        cyc();
        chk("mul_t6_hi_in", hi_in, 1);
        chk("mul_t6_zhi", zhi_out, 1);
        chk("mul_t6_done", done, 1);
        cyc();
        chk("mul_after_alu", alu_opcode, 0);

        // Rejects: ra, rb (binary), rd (binary) out of range
        issue(5'b00011, 4'd2, 4'd9, 4'd1);
        chk("rej_ra_err", err, 1);
        chk("rej_ra_busy", busy, 0);
        chk("rej_ra_reg_out", reg_out, 0);
        cyc();
        chk("rej_ra_err_clear", err, 0);
        issue(5'b00011, 4'd2, 4'd1, 4'd8);
        chk("rej_rb_err", err, 1);
        cyc();
        issue(5'b00011, 4'd8, 4'd1, 4'd2);
        chk("rej_rd_err", err, 1);
        cyc();

        // Unary ignores an out-of-range rb
        issue(5'b10010, 4'd2, 4'd3, 4'd15);
        chk("not_rb15_busy", busy, 1);
        chk("not_rb15_err", err, 0);
        cyc(); cyc(); cyc();

        // start held high and inputs changed while busy are ignored
        opcode = 5'b00011; rd = 4'd2; ra = 4'd0; rb = 4'd1; start = 1'b1;
        cyc();
        opcode = 5'b10010; rd = 4'd3; ra = 4'd3; rb = 4'd3;
        cyc(); cyc();
        chk("hold_t5_reg_in", reg_in, 8'h04);
        cyc();
        start = 1'b0;
        chk("hold_no_reaccept", busy, 0);
        cyc();
        chk("hold_idle", busy, 0);

        // DIV then NEG rd=ra=7 back-to-back with start held into IDLE
        opcode = 5'b10000; rd = 4'd12; ra = 4'd3; rb = 4'd4; start = 1'b1;
        cyc();
        opcode = 5'b10001; rd = 4'd7; ra = 4'd7; rb = 4'd0;
        cyc(); cyc(); cyc();
        chk("div_t6_done", done, 1);
        cyc();
        chk("b2b_idle_gap", busy, 0);
        cyc();
        start = 1'b0;
        chk("neg_t3_reg_out", reg_out, 8'h80);
        chk("neg_t3_reg_in", reg_in, 8'h00);
        cyc();
        chk("neg_t4_reg_out", reg_out, 8'h00);
        chk("neg_t4_alu", alu_opcode, 5'b10001);
        cyc();
        chk("neg_t5_reg_in", reg_in, 8'h80);
        chk("neg_t5_reg_out", reg_out, 8'h00);
        cyc();

        // clr in T4 of MUL aborts before any LO/HI write
        issue(5'b01111, 4'd0, 4'd1, 4'd2);
        cyc();
        chk("clr_mul_t4_z_in", z_in, 1);
        clr = 1'b1;
        cyc();
        chk("clr_busy", busy, 0);
        chk("clr_lo_in", lo_in, 0);
        chk("clr_zlo", zlo_out, 0);
        chk("clr_alu", alu_opcode, 0);
        clr = 1'b0;
        cyc();
        chk("clr_hi_in", hi_in, 0);
        chk("clr_still_idle", busy, 0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
